// File: rtl/datapath_gen.sv
// rtl/datapath_gen.sv - single-bus CPU datapath: register file, ALU, signed MUL/DIV, memory-read port
//
// Purpose : register file plus Y/Z/HI/LO/IR/PC/MAR/MDR/port registers around one OR-combined bus,
//           with a single-cycle ALU, iterative signed MUL/DIV and a req/ack memory read into MDR.
// Ports   : clk, clr (async active-low reset)
//           reg_in/reg_out (one-hot register load/drive), *_in load strobes, *_out bus drivers
//           op, c_data, inport_data          ALU opcode, immediate, input-port value
//           mem_rd/mem_req/mem_addr/mem_ack/mem_rdata/mem_busy   memory read handshake
//           alu_busy, alu_done, div_zero     MUL/DIV status
//           ir_q, outport_q, bus, bus_err    register views and bus debug
// Option  : define DATAPATH_BUSCHK_EN to flag more than one bus source on bus_err (sticky until clr).
module datapath_gen #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NUM_REGS-1:0] reg_in,
    input  logic [NUM_REGS-1:0] reg_out,
    input  logic                y_in,
    input  logic                z_in,
    input  logic                hi_in,
    input  logic                lo_in,
    input  logic                ir_in,
    input  logic                pc_in,
    input  logic                mar_in,
    input  logic                mdr_in,
    input  logic                outport_in,
    input  logic                hi_out,
    input  logic                lo_out,
    input  logic                zhi_out,
    input  logic                zlo_out,
    input  logic                pc_out,
    input  logic                mdr_out,
    input  logic                inport_out,
    input  logic                c_out,
    input  logic [4:0]          op,
    input  logic [DATA_W-1:0]   c_data,
    input  logic [DATA_W-1:0]   inport_data,
    input  logic                mem_rd,
    output logic                mem_req,
    output logic [DATA_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_busy,
    output logic                alu_busy,
    output logic                alu_done,
    output logic                div_zero,
    output logic [DATA_W-1:0]   ir_q,
    output logic [DATA_W-1:0]   outport_q,
    output logic [DATA_W-1:0]   bus,
    output logic                bus_err
);
    localparam int SW = $clog2(DATA_W);

    typedef enum logic [1:0] {A_IDLE, A_RUN, A_FIX} alu_state_t;
    typedef enum logic {M_IDLE, M_WAIT} mem_state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] y_q, zhi_q, zlo_q, hi_q, lo_q, pc_q, mar_q, mdr_q, inport_q;
    alu_state_t        alu_state, alu_next;
    mem_state_t        mem_state, mem_next;

    // MUL/DIV working set: acc_hi:acc_lo is product or remainder:quotient, opnd is |B|
    logic [DATA_W-1:0]   acc_hi, acc_lo, opnd, dividend;
    logic [SW-1:0]       cnt;
    logic                is_div, neg_a, neg_res;
    logic                muldiv_op, muldiv_start;
    logic [DATA_W:0]     mul_sum, rem_sh;
    logic                rem_ge;
    logic [2*DATA_W-1:0] prod;
    logic [SW-1:0]       sh, sh_neg;
    logic [DATA_W-1:0]   alu_res;

    always_comb begin
        bus = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (reg_out[i]) bus = bus | regs[i];
        if (hi_out)     bus = bus | hi_q;
        if (lo_out)     bus = bus | lo_q;
        if (zhi_out)    bus = bus | zhi_q;
        if (zlo_out)    bus = bus | zlo_q;
        if (pc_out)     bus = bus | pc_q;
        if (mdr_out)    bus = bus | mdr_q;
        if (inport_out) bus = bus | inport_q;
        if (c_out)      bus = bus | c_data;
    end

`ifdef DATAPATH_BUSCHK_EN
    logic [NUM_REGS+7:0] srcs;
    logic                err_q;
    assign srcs = {reg_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out};
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                     err_q <= 1'b0;
        else if ($countones(srcs) > 1) err_q <= 1'b1;
    end
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    // Rotates combine both shift directions; sh_neg = DATA_W - sh, and sh = 0 degenerates to A | A.
    always_comb begin
        sh      = bus[SW-1:0];
        sh_neg  = -sh;
        alu_res = '0;
        case (op)
            5'd0:    alu_res = y_q + bus;
            5'd1:    alu_res = y_q - bus;
            5'd2:    alu_res = y_q & bus;
            5'd3:    alu_res = y_q | bus;
            5'd4:    alu_res = y_q >> sh;
            5'd5:    alu_res = $signed(y_q) >>> sh;
            5'd6:    alu_res = y_q << sh;
            5'd7:    alu_res = (y_q >> sh) | (y_q << sh_neg);
            5'd8:    alu_res = (y_q << sh) | (y_q >> sh_neg);
            5'd9:    alu_res = -bus;
            5'd10:   alu_res = ~bus;
            5'd11:   alu_res = bus + DATA_W'(1);
            default: alu_res = '0;
        endcase
    end

    assign muldiv_op    = (op == 5'd12) || (op == 5'd13);
    assign muldiv_start = z_in && muldiv_op && (alu_state == A_IDLE);
    assign mul_sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign rem_sh       = {acc_hi, acc_lo[DATA_W-1]};
    assign rem_ge       = rem_sh >= {1'b0, opnd};
    assign prod         = {acc_hi, acc_lo};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) alu_state <= A_IDLE;
        else      alu_state <= alu_next;
    end

    always_comb begin
        alu_next = alu_state;
        case (alu_state)
            A_IDLE:  if (muldiv_start) alu_next = A_RUN;
            A_RUN:   if (cnt == SW'(DATA_W - 1)) alu_next = A_FIX;
            A_FIX:   alu_next = A_IDLE;
            default: alu_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) mem_state <= M_IDLE;
        else      mem_state <= mem_next;
    end

    always_comb begin
        mem_next = mem_state;
        case (mem_state)
            M_IDLE:  if (mem_rd) mem_next = M_WAIT;
            M_WAIT:  if (mem_ack) mem_next = M_IDLE;
            default: mem_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (reg_in[i]) regs[i] <= bus;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            y_q <= '0; hi_q <= '0; lo_q <= '0; pc_q <= '0; mar_q <= '0;
            mdr_q <= '0; inport_q <= '0; ir_q <= '0; outport_q <= '0;
        end else begin
            inport_q <= inport_data;
            if (y_in)       y_q <= bus;
            if (hi_in)      hi_q <= zhi_q;
            if (lo_in)      lo_q <= zlo_q;
            if (pc_in)      pc_q <= bus;
            if (mar_in)     mar_q <= bus;
            if (ir_in)      ir_q <= bus;
            if (outport_in) outport_q <= bus;
            if (mem_state == M_WAIT && mem_ack) mdr_q <= mem_rdata;
            else if (mdr_in)                    mdr_q <= bus;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_hi <= '0; acc_lo <= '0; opnd <= '0; dividend <= '0; cnt <= '0;
            is_div <= 1'b0; neg_a <= 1'b0; neg_res <= 1'b0; alu_done <= 1'b0;
        end else begin
            alu_done <= (alu_state == A_FIX);
            if (muldiv_start) begin
                is_div   <= (op == 5'd13);
                neg_a    <= y_q[DATA_W-1];
                neg_res  <= y_q[DATA_W-1] ^ bus[DATA_W-1];
                dividend <= y_q;
                opnd     <= bus[DATA_W-1] ? -bus : bus;
                acc_hi   <= '0;
                acc_lo   <= y_q[DATA_W-1] ? -y_q : y_q;
                cnt      <= '0;
            end else if (alu_state == A_RUN) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    // restoring step: the subtraction fits DATA_W bits because the true difference < |B|
                    acc_hi <= rem_ge ? rem_sh[DATA_W-1:0] - opnd : rem_sh[DATA_W-1:0];
                    acc_lo <= {acc_lo[DATA_W-2:0], rem_ge};
                end else begin
                    acc_hi <= mul_sum[DATA_W:1];
                    acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zhi_q <= '0; zlo_q <= '0; div_zero <= 1'b0;
        end else if (alu_state == A_FIX) begin
            if (!is_div) begin
                {zhi_q, zlo_q} <= neg_res ? -prod : prod;
            end else if (opnd == '0) begin
                zlo_q    <= '1;
                zhi_q    <= dividend;
                div_zero <= 1'b1;
            end else begin
                zlo_q    <= neg_res ? -acc_lo : acc_lo;
                zhi_q    <= neg_a ? -acc_hi : acc_hi;
                div_zero <= 1'b0;
            end
        end else if (z_in && !muldiv_op && alu_state == A_IDLE) begin
            zlo_q <= alu_res;
            zhi_q <= '0;
        end
    end

    assign mem_req  = (mem_state == M_WAIT);
    assign mem_busy = (mem_state == M_WAIT);
    assign mem_addr = mar_q;
    assign alu_busy = (alu_state != A_IDLE);

endmodule

// File: tb/tb_datapath_gen.sv
// tb/tb_datapath_gen.sv - scoreboard bench for datapath_gen
module tb_datapath_gen;
    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] reg_in, reg_out;
    logic        y_in, z_in, hi_in, lo_in, ir_in, pc_in, mar_in, mdr_in, outport_in;
    logic        hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
    logic [4:0]  op;
    logic [31:0] c_data, inport_data, mem_addr, mem_rdata, ir_q, outport_q, bus;
    logic        mem_rd, mem_req, mem_ack, mem_busy, alu_busy, alu_done, div_zero, bus_err;

    datapath_gen #(.DATA_W(32), .NUM_REGS(16)) dut (
        .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .ir_in(ir_in), .pc_in(pc_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in),
        .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out), .pc_out(pc_out),
        .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
        .op(op), .c_data(c_data), .inport_data(inport_data),
        .mem_rd(mem_rd), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .alu_busy(alu_busy), .alu_done(alu_done),
        .div_zero(div_zero), .ir_q(ir_q), .outport_q(outport_q), .bus(bus), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

`ifdef DATAPATH_BUSCHK_EN
    localparam logic [63:0] BE_FLAG = 64'h20;
`else
    localparam logic [63:0] BE_FLAG = 64'h0;
`endif

    typedef struct {
        string       name;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          busy_cnt;
    logic        obs_valid;
    logic [2:0]  obs_sel;
    logic [63:0] obs;
    logic [31:0] prev_lo;

    // flags: {bus_err, div_zero, alu_done, alu_busy, mem_busy, mem_req}
    always_comb begin
        case (obs_sel)
            3'd0:    obs = {32'h0, bus};
            3'd1:    obs = {32'h0, mem_addr};
            3'd2:    obs = {58'h0, bus_err, div_zero, alu_done, alu_busy, mem_busy, mem_req};
            3'd3:    obs = 64'(busy_cnt);
            3'd4:    obs = {32'h0, ir_q};
            3'd5:    obs = {32'h0, outport_q};
            default: obs = 64'h0;
        endcase
    end

    always @(negedge clk) begin : monitor
        exp_t t;
        if (obs_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow: observation with no expectation, got %h", obs);
            end else begin
                t = sb.pop_front();
                if (obs !== t.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", t.name, obs, t.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        reg_in = '0; reg_out = '0;
        {y_in, z_in, hi_in, lo_in, ir_in, pc_in, mar_in, mdr_in, outport_in} = '0;
        {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out} = '0;
        mem_rd = 1'b0; mem_ack = 1'b0; obs_valid = 1'b0;
    endtask

    task automatic check(input logic [2:0] sel, input logic [63:0] e, input string nm);
        exp_t t;
        t.name = nm;
        t.exp  = e;
        sb.push_back(t);
        obs_sel   = sel;
        obs_valid = 1'b1;
        tick();
    endtask

    task automatic put_c(input logic [31:0] v);
        c_data = v;
        c_out  = 1'b1;
    endtask

    logic [4:0]  s_op [13] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd7, 5'd9, 5'd10, 5'd20, 5'd11};
    logic [31:0] s_b  [13] = '{32'h10, 32'hFF00FF00, 32'h0F0000F0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8,
                               32'h20, 32'h1, 32'h0F0F0F0F, 32'h5, 32'h7FFFFFFF};
    logic [31:0] s_e  [13] = '{32'hEFFFFFFF, 32'hF0000000, 32'hFF0000FF, 32'h0F000000, 32'hFF000000,
                               32'h000000F0, 32'hFF000000, 32'h00000FF0, 32'hF000000F, 32'hFFFFFFFF,
                               32'hF0F0F0F0, 32'h0, 32'h80000000};

    logic [4:0]  m_op [8] = '{5'd12, 5'd12, 5'd12, 5'd13, 5'd13, 5'd12, 5'd13, 5'd13};
    logic [31:0] m_a  [8] = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'h3, 32'h7, 32'd100};
    logic [31:0] m_b  [8] = '{32'h7, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h5, 32'hFFFFFFFE, 32'h7};
    logic [31:0] m_hi [8] = '{32'hFFFFFFFF, 32'h3FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h0,
                              32'h1, 32'h2};
    logic [31:0] m_lo [8] = '{32'hFFFFFFEB, 32'h00000001, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'hF, 32'hFFFFFFFD, 32'hE};
    logic        m_dz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; obs_valid = 1'b0; obs_sel = '0; op = '0; c_data = '0;
        inport_data = 32'h1234_5678; mem_rdata = '0; busy_cnt = 0;
        reg_in = '0; reg_out = '0;
        {y_in, z_in, hi_in, lo_in, ir_in, pc_in, mar_in, mdr_in, outport_in} = '0;
        {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out} = '0;
        mem_rd = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        reg_out = '1; {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out} = '1;
        check(3'd0, 64'h0, "reset_bus");
        check(3'd2, 64'h0, "reset_flags");
        check(3'd1, 64'h0, "reset_mem_addr");
        check(3'd4, 64'h0, "reset_ir");
        check(3'd5, 64'h0, "reset_outport");
        clr = 1'b1;
        tick();

        put_c(32'h5);          reg_in[1] = 1'b1; tick();
        put_c(32'hFFFF_FFFD);  reg_in[2] = 1'b1; tick();
        reg_out[1] = 1'b1; y_in = 1'b1; tick();
        reg_out[2] = 1'b1; op = 5'd0; z_in = 1'b1; tick();
        zlo_out = 1'b1; check(3'd0, 64'h2, "add_zlo");
        zhi_out = 1'b1; check(3'd0, 64'h0, "add_zhi");
        lo_in = 1'b1; tick();
        lo_out = 1'b1; check(3'd0, 64'h2, "add_lo");

        put_c(32'hF000_000F); y_in = 1'b1; tick();
        for (int i = 0; i < 13; i++) begin
            put_c(s_b[i]); op = s_op[i]; z_in = 1'b1; tick();
            zlo_out = 1'b1; check(3'd0, {32'h0, s_e[i]}, $sformatf("single_op%0d_row%0d", s_op[i], i));
        end
        zhi_out = 1'b1; check(3'd0, 64'h0, "single_zhi");
        prev_lo = 32'h8000_0000;

        for (int i = 0; i < 8; i++) begin
            put_c(m_a[i]); y_in = 1'b1; tick();
            put_c(m_b[i]); op = m_op[i]; z_in = 1'b1; tick();
            busy_cnt = 0;
            while (alu_busy && busy_cnt < 100) begin
                busy_cnt++;
                if (busy_cnt == 5) begin
                    zlo_out = 1'b1; z_in = 1'b1; op = 5'd0;
                    check(3'd0, {32'h0, prev_lo}, $sformatf("busy_old_z_row%0d", i));
                end else begin
                    tick();
                end
            end
            check(3'd2, m_dz[i] ? 64'h18 : 64'h08, $sformatf("muldiv_done_flags_row%0d", i));
            check(3'd3, 64'd33, $sformatf("muldiv_busy_cycles_row%0d", i));
            zlo_out = 1'b1; check(3'd0, {32'h0, m_lo[i]}, $sformatf("muldiv_zlo_row%0d", i));
            zhi_out = 1'b1; check(3'd0, {32'h0, m_hi[i]}, $sformatf("muldiv_zhi_row%0d", i));
            prev_lo = m_lo[i];
        end
        check(3'd2, 64'h0, "done_pulse_ends");
        hi_in = 1'b1; tick();
        hi_out = 1'b1; check(3'd0, 64'h2, "hi_from_z");

        put_c(32'h0BAD_F00D); ir_in = 1'b1; outport_in = 1'b1; pc_in = 1'b1; tick();
        check(3'd4, 64'h0BAD_F00D, "ir_load");
        check(3'd5, 64'h0BAD_F00D, "outport_load");
        pc_out = 1'b1; check(3'd0, 64'h0BAD_F00D, "pc_load");
        inport_out = 1'b1; check(3'd0, 64'h1234_5678, "inport_a");
        inport_data = 32'hA5A5_A5A5; tick();
        inport_out = 1'b1; check(3'd0, 64'hA5A5_A5A5, "inport_b");

        put_c(32'h40); mar_in = 1'b1; tick();
        mem_rd = 1'b1; tick();
        check(3'd2, 64'h3, "mem_req_up");
        check(3'd1, 64'h40, "mem_addr_40");
        mem_rd = 1'b1; tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; put_c(32'h1111_1111); mdr_in = 1'b1; tick();
        check(3'd2, 64'h0, "mem_req_drop");
        mdr_out = 1'b1; check(3'd0, 64'hDEAD_BEEF, "mdr_ack_wins");
        mem_rd = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; tick();
        mem_ack = 1'b1; check(3'd2, 64'h3, "min_read_req");
        check(3'd2, 64'h0, "min_read_done");
        mdr_out = 1'b1; check(3'd0, 64'hCAFE_F00D, "min_read_mdr");
        put_c(32'h1357); mdr_in = 1'b1; tick();
        mdr_out = 1'b1; check(3'd0, 64'h1357, "mdr_from_bus");

        put_c(32'h80); mar_in = 1'b1; tick();
        mem_rd = 1'b1; tick();
        check(3'd2, 64'h3, "mem_req_before_clr");
        clr = 1'b0;
        check(3'd2, 64'h0, "clr_mid_read_flags");
        mdr_out = 1'b1; check(3'd0, 64'h0, "clr_mid_read_mdr");
        check(3'd1, 64'h0, "clr_mar");
        clr = 1'b1; tick();

        put_c(32'h3); y_in = 1'b1; tick();
        put_c(32'h5); op = 5'd12; z_in = 1'b1; tick();
        repeat (4) tick();
        check(3'd2, 64'h04, "mid_mul_busy");
        clr = 1'b0;
        check(3'd2, 64'h0, "clr_mid_mul_flags");
        zlo_out = 1'b1; check(3'd0, 64'h0, "clr_mid_mul_z");
        clr = 1'b1; tick();
        repeat (40) tick();
        check(3'd2, 64'h0, "no_done_after_abort");

        put_c(32'h0F); reg_in[0] = 1'b1; tick();
        put_c(32'hF0); pc_in = 1'b1; tick();
        check(3'd2, 64'h0, "bus_err_clean");
        reg_out[0] = 1'b1; pc_out = 1'b1; check(3'd0, 64'hFF, "bus_or_sources");
        check(3'd2, BE_FLAG, "bus_err_set");
        repeat (3) tick();
        check(3'd2, BE_FLAG, "bus_err_hold");
        clr = 1'b0;
        check(3'd2, 64'h0, "bus_err_clr");
        clr = 1'b1;
        repeat (2) tick();

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover: %0d expectations unconsumed, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/datapath_gen.md
# datapath_gen

Parametrised successor to the single-bus CPU datapath: a NUM_REGS × DATA_W register file, Y/Z/HI/LO/IR/PC/MAR/MDR and I/O-port registers around one shared bus, with a single-cycle ALU plus multi-cycle signed MUL/DIV and a request/acknowledge memory-read port. It sits under the control unit, which drives one-hot in/out strobes each step and waits on `alu_busy` / `mem_busy`.

## Interface
- DATA_W, 32, bus and register width (≥8, even)
- NUM_REGS, 16, general registers (2..32)
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  asynchronous, active-low reset
- reg_in  in  NUM_REGS  one-hot register load strobes from bus
- reg_out  in  NUM_REGS  one-hot register bus drivers
- y_in, z_in, hi_in, lo_in, ir_in, pc_in, mar_in, mdr_in, outport_in  in  1 each  load strobes
- hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out  in  1 each  bus drivers
- op  in  5  ALU opcode
- c_data  in  DATA_W  constant/immediate source
- inport_data  in  DATA_W  input-port value, sampled every cycle
- mem_rd  in  1  start memory read into MDR
- mem_req  out  1  read request; mem_addr valid while high
- mem_addr  out  DATA_W  MAR contents
- mem_ack  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- mem_busy  out  1  read outstanding
- alu_busy  out  1  MUL/DIV in progress
- alu_done  out  1  one-cycle pulse when Z written by MUL/DIV
- div_zero  out  1  sticky; last DIV had zero divisor
- ir_q, outport_q  out  DATA_W  IR and output-port contents
- bus  out  DATA_W  bus value (debug)
- bus_err  out  1  sticky multi-driver flag (see Configuration)

## Operation
- Bus is combinational bitwise OR of all asserted sources; no source → 0.
- Load strobes capture `bus` at the edge; HI/LO load from Z high/low, not bus.
- ALU operand A = Y, operand B = bus. op: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 SHR logical, 5 SHRA, 6 SHL, 7 ROR, 8 ROL (shift amount B[log2 DATA_W−1:0]), 9 NEG B, 10 NOT B, 11 INC B (+1), 12 MUL, 13 DIV; 14–31 → Z = 0.
- Single-cycle ops: z_in loads Zlo = result, Zhi = 0 (SUB/ADD carries discarded).
- MUL/DIV (signed two's complement): z_in latches A, B, op; alu_busy=1. States IDLE → RUN (DATA_W cycles shift-add / restoring divide on magnitudes) → FIX (sign correction, writes Z) → IDLE.
  - MUL: Z = full 2·DATA_W product. DIV: Zlo = quotient (truncate toward zero), Zhi = remainder (sign of dividend).
  - Divisor 0: Zlo = all ones, Zhi = dividend, div_zero set; cleared by next non-zero DIV.
  - While alu_busy: z_in ignored, zhi_out/zlo_out drive old Z.
- Memory: mem_rd in IDLE → mem_req=1, mem_busy=1 until edge with mem_ack; that edge loads MDR ← mem_rdata, mem_req drops next cycle. mem_rd while busy ignored. mdr_in and mem_ack same edge: mem_ack wins.
- Reset: all registers, Z, MDR, MAR, outport 0; FSMs IDLE; all outputs 0.

## Timing
- Load strobe at edge k → value visible on bus from k+ε.
- Single-cycle op: Z valid the cycle after z_in.
- MUL/DIV: z_in at edge k; alu_busy high k..k+DATA_W+1; alu_done high the cycle after edge k+DATA_W+1 (Z valid).
- mem_req rises the cycle after mem_rd edge; min read = 2 cycles (ack held high).
- clr low mid-MUL/DIV or mid-read: aborts immediately, busy flags and mem_req 0, Z/MDR 0.

## Configuration
- DATAPATH_BUSCHK_EN defined: bus_err set when >1 bus source asserted in a cycle, held until clr; bus still ORs sources.
- Undefined: no detection logic, bus_err tied 0.

## Test plan
- Reset: clr low → all regs, Z, outputs 0; bus_err 0, mem_req 0.
- ADD: R1=0x0000_0005, R2=0xFFFF_FFFD; Y←R1, op 0, R2out, z_in → Zlo=0x0000_0002, Zhi=0; lo_in → LO=2.
- MUL: Y=−3 (0xFFFF_FFFD), B=7, op 12 → alu_busy 33 cycles, alu_done pulse, Z=0xFFFF_FFFF_FFFF_FFEB.
- DIV: Y=−7, B=2 → Zlo=0xFFFF_FFFD, Zhi=0xFFFF_FFFF; divisor 0 → Zlo=0xFFFF_FFFF, Zhi=dividend, div_zero=1.
- Memory: MAR=0x40, mem_rd, ack after 3 cycles with 0xDEAD_BEEF → mem_addr=0x40 while req, MDR=0xDEAD_BEEF, mem_busy drops; clr mid-wait → req 0.
- With DATAPATH_BUSCHK_EN: reg_out[0] and pc_out together one cycle → bus_err=1 and stays 1 until clr.
